uart_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_fsm.sv | 114 +++++++++++
 rtl/uart_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller: bus addresses, UART_CON bit
// positions and the RX/TX state encodings.
package uart_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int CON_TX_IRQ_EN  = 0;
    localparam int CON_RX_IRQ_EN  = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_VALID   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;
    localparam int CON_FRAME_ERR  = 6;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 receiver: rxd synchronizer, start-bit qualification, LSB-first shift
// register and stop-bit check; reports one-cycle rx_done / frame_err pulses.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int OSR = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rxd,
    output logic       rx_done,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OSR - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             start_edge;
    logic             half_point;
    logic             full_point;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign half_point = tick && (tick_cnt == HALF_LAST);
    assign full_point = tick && (tick_cnt == FULL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (start_edge) state_next = RX_START;
            RX_START: if (half_point) state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_point && bit_cnt == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (full_point) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_done   = 1'b0;
        frame_err = 1'b0;
        if (state == RX_STOP && full_point) begin
            rx_done   = rx_sync;
            frame_err = ~rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
                RX_START: begin
                    if (half_point)
                        tick_cnt <= '0;
                    else if (tick)
                        tick_cnt <= tick_cnt + CNT_W'(1);
                end
                default: begin
                    if (full_point) begin
                        tick_cnt <= '0;
                        if (state == RX_DATA)
                            bit_cnt <= bit_cnt + 3'd1;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == RX_DATA && full_point)
            shift <= {rx_sync, shift[7:1]};
    end

    assign rx_byte = shift;

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART: baud tick generator, transmitter, register file
// and interrupt; the receiver lives in uart_rx_fsm.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int OSR      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rxd,
    output logic        txd,
    output logic        irqout
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OSR);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OSR - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    tx_state_t        tx_state;
    tx_state_t        tx_state_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_full;
    logic             tx_busy;
    logic             tx_end;
    logic             txd_next;
    logic             txd_wr;

    logic             sel_txd;
    logic             sel_rxd;
    logic             sel_con;

    logic             tx_irq_en;
    logic             rx_irq_en;
    logic             tx_done;
    logic             rx_valid;
    logic             rx_overrun;
    logic             frame_err;
    logic [7:0]       rx_data;

    logic             rx_done;
    logic [7:0]       rx_byte;
    logic             rx_ferr;
    logic             unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    assign tick = (div_cnt == DIV_LAST);

    assign sel_txd = (addr == UART_TXD_ADDR);
    assign sel_rxd = (addr == UART_RXD_ADDR);
    assign sel_con = (addr == UART_CON_ADDR);

    // Busy covers the whole last stop-bit cycle, so a write landing there is dropped.
    assign tx_busy = (tx_state != TX_IDLE);
    assign txd_wr  = wr && sel_txd && !tx_busy;
    assign tx_full = tick && (tx_cnt == FULL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (txd_wr) tx_state_next = TX_START;
            TX_START: if (tx_full) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_full && tx_bit == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_full) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        txd_next = 1'b1;
        tx_end   = 1'b0;
        case (tx_state)
            TX_START: txd_next = 1'b0;
            TX_DATA:  txd_next = tx_shift[tx_bit];
            TX_STOP:  tx_end   = tx_full;
            default:  txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            txd    <= 1'b1;
        end else begin
            txd <= txd_next;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                tx_bit <= '0;
            end else if (tx_full) begin
                tx_cnt <= '0;
                if (tx_state == TX_DATA)
                    tx_bit <= tx_bit + 3'd1;
            end else if (tick) begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (txd_wr)
            tx_shift <= wdata[7:0];
    end

    uart_rx_fsm #(
        .OSR(OSR)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .rxd      (rxd),
        .rx_done  (rx_done),
        .rx_byte  (rx_byte),
        .frame_err(rx_ferr)
    );

    // Status flags: a set event in the same cycle as a clearing read wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_irq_en  <= 1'b0;
            rx_irq_en  <= 1'b0;
            tx_done    <= 1'b0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_data    <= '0;
            irqout     <= 1'b0;
        end else begin
            if (wr && sel_con) begin
                tx_irq_en <= wdata[CON_TX_IRQ_EN];
                rx_irq_en <= wdata[CON_RX_IRQ_EN];
            end
            if (tx_end)
                tx_done <= 1'b1;
            else if (rd && sel_con)
                tx_done <= 1'b0;
            if (rx_done)
                rx_valid <= 1'b1;
            else if (rd && sel_rxd)
                rx_valid <= 1'b0;
            if (rx_done && rx_valid)
                rx_overrun <= 1'b1;
            else if (rd && sel_con)
                rx_overrun <= 1'b0;
            if (rx_ferr)
                frame_err <= 1'b1;
            else if (rd && sel_con)
                frame_err <= 1'b0;
            if (rx_done)
                rx_data <= rx_byte;
            irqout <= (tx_done & tx_irq_en) | (rx_valid & rx_irq_en);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rxd) begin
                rdata[7:0] = rx_data;
            end else if (sel_con) begin
                rdata[CON_TX_IRQ_EN]  = tx_irq_en;
                rdata[CON_RX_IRQ_EN]  = rx_irq_en;
                rdata[CON_TX_DONE]    = tx_done;
                rdata[CON_RX_VALID]   = rx_valid;
                rdata[CON_TX_BUSY]    = tx_busy;
                rdata[CON_RX_OVERRUN] = rx_overrun;
                rdata[CON_FRAME_ERR]  = frame_err;
            end
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: bus reads and transmitted frames are
// checked by monitors against expectations queued by the stimulus.
module tb_uart_ctrl;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int OSR      = 16;
    localparam int BIT_CLK  = CLK_FREQ / BAUD;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rxd = 1'b1;
    logic        txd;
    logic        irqout;

    uart_ctrl #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .OSR     (OSR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .rxd   (rxd),
        .txd   (txd),
        .irqout(irqout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_exp_q[$];
    bit          mon_en = 1'b0;

    // Behavioural view of the register state as the CPU would see it.
    bit         m_txen, m_rxen, m_done, m_valid, m_busy, m_ovr, m_fe;
    logic [7:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] con_model();
        return {25'd0, m_fe, m_ovr, m_busy, m_valid, m_done, m_rxen, m_txen};
    endfunction

    task automatic model_reset();
        m_txen = 0; m_rxen = 0; m_done = 0; m_valid = 0;
        m_busy = 0; m_ovr = 0; m_fe = 0; m_data = 8'h00;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 wr = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1 wr = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(posedge clk);
        #1 rd = 1'b1; addr = a;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    task automatic read_con(input string name);
        bus_read(name, A_CON, con_model());
        m_done = 0; m_ovr = 0; m_fe = 0;
    endtask

    task automatic read_rxd(input string name);
        bus_read(name, A_RXD, {24'd0, m_data});
        m_valid = 0;
    endtask

    task automatic write_con(input logic [1:0] en);
        bus_write(A_CON, {30'd0, en});
        m_txen = en[0];
        m_rxen = en[1];
    endtask

    task automatic check_irq(input string name);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(name, 32'(irqout), 32'((m_done & m_txen) | (m_valid & m_rxen)));
    endtask

    task automatic drive_bit(input logic v);
        #1 rxd = v;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(b[k]);
        drive_bit(stop);
        #1 rxd = 1'b1;
        if (stop) begin
            if (m_valid) m_ovr = 1;
            m_valid = 1;
            m_data  = b;
        end else begin
            m_fe = 1;
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic tx_frame(input string name, input logic [7:0] b);
        bus_write(A_TXD, {24'd0, b});
        tx_exp_q.push_back(b);
        m_busy = 1;
        repeat (800) @(posedge clk);
        read_con(name);
        repeat (900) @(posedge clk);
        m_busy = 0;
        m_done = 1;
    endtask

    // Read monitor: every bus read cycle is compared with the oldest expectation.
    string       rd_name;
    logic [31:0] rd_exp;
    always @(negedge clk) begin
        if (rd) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h, expected no read", rdata);
            end else begin
                rd_name = rd_name_q.pop_front();
                rd_exp  = rd_exp_q.pop_front();
                check(rd_name, rdata, rd_exp);
            end
        end
    end

    // Serial monitor: decodes each txd frame at bit centres.
    initial begin : tx_mon
        logic [7:0] b;
        logic       s0;
        logic       sp;
        wait (mon_en);
        forever begin
            @(negedge txd);
            repeat (BIT_CLK / 2) @(negedge clk);
            s0 = txd;
            for (int k = 0; k < 8; k++) begin
                repeat (BIT_CLK) @(negedge clk);
                b[k] = txd;
            end
            repeat (BIT_CLK) @(negedge clk);
            sp = txd;
            check("tx_start_bit", 32'(s0), 32'd0);
            check("tx_stop_bit", 32'(sp), 32'd1);
            if (tx_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected_frame: got 0x%02h, expected no frame", b);
            end else begin
                check("tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
            end
        end
    end

    initial begin : stim
        logic [7:0] b;
        model_reset();
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;

        repeat (2000) @(posedge clk);
        @(negedge clk);
        check("idle_txd", 32'(txd), 32'd1);
        check("idle_irqout", 32'(irqout), 32'd0);
        read_con("reset_con");
        read_rxd("reset_rxd");

        write_con(2'b01);
        tx_frame("tx_busy_con", 8'hA5);
        check_irq("tx_done_irq");
        read_con("tx_done_con");
        read_con("tx_done_cleared");
        check_irq("tx_irq_cleared");

        for (int i = 0; i < 3; i++) begin
            write_con(2'($urandom_range(0, 3)));
            tx_frame("tx_rand_busy", 8'($urandom));
            check_irq("tx_rand_irq");
            read_con("tx_rand_con");
        end

        write_con(2'b10);
        rx_frame(8'h3C, 1'b1);
        check_irq("rx_irq");
        read_con("rx_valid_con");
        @(posedge clk);
        #1 addr = A_RXD;
        @(negedge clk);
        check("rdata_no_rd", rdata, 32'd0);
        read_rxd("rx_data");
        read_con("rx_valid_cleared");

        for (int i = 0; i < 3; i++) begin
            rx_frame(8'($urandom), 1'b1);
            read_rxd("rx_rand_data");
            read_con("rx_rand_con");
        end

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        read_con("overrun_con");
        read_con("overrun_cleared");
        read_rxd("overrun_data");

        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (400) @(posedge clk);
        read_con("glitch_con");

        rx_frame(8'($urandom), 1'b0);
        read_con("frame_err_con");
        read_con("frame_err_cleared");
        read_rxd("frame_err_data");

        bus_write(A_TXD, 32'h55);
        tx_exp_q.push_back(8'h55);
        m_busy = 1;
        repeat (100) @(posedge clk);
        bus_write(A_TXD, 32'h66);
        repeat (1700) @(posedge clk);
        m_busy = 0;
        m_done = 1;
        read_con("tx_ignore_con");
        repeat (1800) @(posedge clk);

        write_con(2'b11);
        @(posedge clk);
        drive_bit(1'b0);
        for (int k = 0; k < 3; k++) drive_bit(k[0]);
        #1 reset = 1'b0;
        rxd = 1'b1;
        model_reset();
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irqout", 32'(irqout), 32'd0);
        read_con("rst_con");
        read_rxd("rst_rxd");

        b = 8'($urandom);
        rx_frame(b, 1'b1);
        read_rxd("post_rst_data");

        repeat (5) @(posedge clk);
        check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
        check("read_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
